// File: rtl/wb_stage_pipe_if.sv
// Handshake and writeback bus between the MEM/WB boundary and the register file port.
// master drives instructions and out_ready; slave is the writeback stage.
interface wb_stage_pipe_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    // A transfer happens on an edge where valid && ready; valid never waits on ready.
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            in_wb_sel;
    logic                  in_reg_write;
    logic [REG_ADDR_W-1:0] in_dest;
    logic [DATA_W-1:0]     in_alu_result;
    logic [DATA_W-1:0]     in_read_data;
    logic [DATA_W-1:0]     in_link_addr;
    logic [1:0]            in_load_size;
    logic                  in_load_unsigned;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     wb_data;
    logic                  wb_reg_write;
    logic [REG_ADDR_W-1:0] wb_dest;
    logic                  misalign_err;
    logic [CNT_W-1:0]      retired_count;

    modport master (
        output flush, in_valid, in_wb_sel, in_reg_write, in_dest, in_alu_result,
               in_read_data, in_link_addr, in_load_size, in_load_unsigned, out_ready,
        input  in_ready, out_valid, wb_data, wb_reg_write, wb_dest, misalign_err,
               retired_count
    );

    modport slave (
        input  flush, in_valid, in_wb_sel, in_reg_write, in_dest, in_alu_result,
               in_read_data, in_link_addr, in_load_size, in_load_unsigned, out_ready,
        output in_ready, out_valid, wb_data, wb_reg_write, wb_dest, misalign_err,
               retired_count
    );
endinterface

// File: rtl/wb_stage_pipe.sv
// MIPS writeback stage: selects and extends the writeback value, holds it under
// valid/ready back-pressure, and counts retired instructions.
module wb_stage_pipe #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input logic            clk,
    input logic            rst,
    wb_stage_pipe_if.slave bus
);
    localparam int OFF_W = $clog2(DATA_W / 8);

    logic [OFF_W-1:0]      offset;
    logic [DATA_W-1:0]     shifted;
    logic                  ext;
    logic [DATA_W-1:0]     mem_data;
    logic                  mem_misalign;
    logic [DATA_W-1:0]     sel_data;
    logic                  load_misalign;
    logic                  gated_write;
    logic                  accept;
    logic                  complete;

    logic                  valid_q;
    logic [DATA_W-1:0]     data_q;
    logic                  write_q;
    logic [REG_ADDR_W-1:0] dest_q;
    logic                  misalign_q;
    logic [CNT_W-1:0]      count_q;

    assign offset  = bus.in_alu_result[OFF_W-1:0];
    assign shifted = bus.in_read_data >> {offset, 3'b000};
    assign ext     = !bus.in_load_unsigned;

    // Fill with the extension bit first, then overlay the extracted lane.
    always_comb begin
        mem_data     = '0;
        mem_misalign = 1'b0;
        case (bus.in_load_size)
            2'b00: begin
                mem_data      = {DATA_W{ext & shifted[7]}};
                mem_data[7:0] = shifted[7:0];
            end
            2'b01: begin
                mem_data       = {DATA_W{ext & shifted[15]}};
                mem_data[15:0] = shifted[15:0];
                mem_misalign   = offset[0];
            end
            2'b10: begin
                mem_data       = {DATA_W{ext & shifted[31]}};
                mem_data[31:0] = shifted[31:0];
                mem_misalign   = |offset[1:0];
            end
            default: begin
                mem_data     = bus.in_read_data;
                mem_misalign = |offset;
            end
        endcase
    end

    always_comb begin
        sel_data = bus.in_alu_result;
        case (bus.in_wb_sel)
            2'b01:   sel_data = mem_data;
            2'b10:   sel_data = bus.in_link_addr;
            default: sel_data = bus.in_alu_result;
        endcase
    end

    assign load_misalign = (bus.in_wb_sel == 2'b01) && mem_misalign;
    assign gated_write   = bus.in_reg_write && (bus.in_dest != '0) && !load_misalign;

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready && !bus.flush;
    assign complete     = valid_q && bus.out_ready;

    // The write strobe is cleared whenever the slot empties so it always equals
    // out_valid && gated reg_write without any output-side logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            data_q     <= '0;
            write_q    <= 1'b0;
            dest_q     <= '0;
            misalign_q <= 1'b0;
            count_q    <= '0;
        end else begin
            if (complete) begin
                count_q <= count_q + 1'b1;
            end
            if (accept) begin
                valid_q    <= 1'b1;
                data_q     <= sel_data;
                write_q    <= gated_write;
                dest_q     <= bus.in_dest;
                misalign_q <= load_misalign;
            end else if (complete || bus.flush) begin
                valid_q    <= 1'b0;
                write_q    <= 1'b0;
                misalign_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid     = valid_q;
    assign bus.wb_data       = data_q;
    assign bus.wb_reg_write  = write_q;
    assign bus.wb_dest       = dest_q;
    assign bus.misalign_err  = misalign_q;
    assign bus.retired_count = count_q;
endmodule

// File: tb/tb_wb_stage_pipe.sv
// Bench for wb_stage_pipe: directed vector table, hand-written multi-cycle
// sequences, then randomized traffic against a cycle-level reference model.
module tb_wb_stage_pipe;
    localparam int DATA_W = 32;
    localparam int RA_W   = 5;
    localparam int CNT_W  = 4;

    typedef struct {
        logic [1:0]  sel;
        logic        rw;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] rd;
        logic [31:0] link;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] exp_data;
        logic        exp_write;
        logic        exp_mis;
    } vec_t;

    typedef struct packed {
        logic [31:0] data;
        logic        write;
        logic        mis;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   exp_cnt = 0;
    logic [DATA_W-1:0] exp_q[$];
    vec_t vecs[14];

    wb_stage_pipe_if #(.DATA_W(DATA_W), .REG_ADDR_W(RA_W), .CNT_W(CNT_W)) bus ();

    wb_stage_pipe #(.DATA_W(DATA_W), .REG_ADDR_W(RA_W), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] sel, input logic rw, input logic [4:0] dest,
                         input logic [31:0] alu, input logic [31:0] rd, input logic [31:0] link,
                         input logic [1:0] size, input logic uns);
        bus.in_valid         = 1'b1;
        bus.in_wb_sel        = sel;
        bus.in_reg_write     = rw;
        bus.in_dest          = dest;
        bus.in_alu_result    = alu;
        bus.in_read_data     = rd;
        bus.in_link_addr     = link;
        bus.in_load_size     = size;
        bus.in_load_unsigned = uns;
    endtask

    function automatic vec_t mk(input logic [1:0] sel, input logic rw, input logic [4:0] dest,
                                input logic [31:0] alu, input logic [31:0] rd,
                                input logic [31:0] link, input logic [1:0] size, input logic uns,
                                input logic [31:0] ed, input logic ew, input logic em);
        vec_t v;
        v.sel = sel; v.rw = rw; v.dest = dest; v.alu = alu; v.rd = rd; v.link = link;
        v.size = size; v.uns = uns; v.exp_data = ed; v.exp_write = ew; v.exp_mis = em;
        return v;
    endfunction

    // Loads read n bytes starting at byte (alu mod 4); misaligned unless the
    // start byte is a multiple of the access size.
    function automatic res_t ref_model(input logic [1:0] sel, input logic rw,
                                       input logic [4:0] dest, input logic [31:0] alu,
                                       input logic [31:0] rd, input logic [31:0] link,
                                       input logic [1:0] size, input logic uns);
        res_t   r;
        int     off;
        int     nbytes;
        longint v;
        longint span;
        r.mis = 1'b0;
        if (sel == 2'b01) begin
            off    = int'(alu % 4);
            nbytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
            span   = longint'(1) << (8 * nbytes);
            v      = (longint'(rd) >> (8 * off)) % span;
            if (!uns && v >= span / 2) v = v - span;
            r.data = 32'(v);
            r.mis  = (off % nbytes) != 0;
        end else if (sel == 2'b10) begin
            r.data = link;
        end else begin
            r.data = alu;
        end
        r.write = rw && (dest != 0) && !r.mis;
        return r;
    endfunction

    initial begin
        bit          m_valid;
        logic [31:0] m_data;
        logic [4:0]  m_dest;
        bit          m_write;
        bit          m_mis;
        int          m_cnt;
        bit          acc;
        bit          comp;
        res_t        r;
        logic [DATA_W-1:0] got;

        vecs[0]  = mk(2'b01, 1, 8,  32'h1002,     32'h11803344, 32'h0,        2'b00, 0, 32'hFFFFFF80, 1, 0);
        vecs[1]  = mk(2'b01, 1, 8,  32'h1002,     32'h11803344, 32'h0,        2'b00, 1, 32'h00000080, 1, 0);
        vecs[2]  = mk(2'b01, 1, 9,  32'h0003,     32'h11803344, 32'h0,        2'b01, 0, 32'h0,        0, 1);
        vecs[3]  = mk(2'b10, 1, 31, 32'h1234,     32'h0,        32'h00400008, 2'b00, 0, 32'h00400008, 1, 0);
        vecs[4]  = mk(2'b10, 1, 0,  32'h1234,     32'h0,        32'h00400008, 2'b00, 0, 32'h00400008, 0, 0);
        vecs[5]  = mk(2'b01, 1, 2,  32'h0002,     32'h80011234, 32'h0,        2'b01, 0, 32'hFFFF8001, 1, 0);
        vecs[6]  = mk(2'b01, 1, 3,  32'h0004,     32'hDEADBEEF, 32'h0,        2'b10, 0, 32'hDEADBEEF, 1, 0);
        vecs[7]  = mk(2'b01, 1, 4,  32'h0006,     32'hDEADBEEF, 32'h0,        2'b10, 0, 32'h0,        0, 1);
        vecs[8]  = mk(2'b11, 1, 6,  32'h12345677, 32'hFFFFFFFF, 32'h0,        2'b01, 0, 32'h12345677, 1, 0);
        vecs[9]  = mk(2'b00, 0, 7,  32'h00000055, 32'h0,        32'h0,        2'b00, 0, 32'h00000055, 0, 0);
        vecs[10] = mk(2'b01, 1, 10, 32'h0010,     32'hCAFEF00D, 32'h0,        2'b11, 0, 32'hCAFEF00D, 1, 0);
        vecs[11] = mk(2'b01, 1, 11, 32'h0007,     32'hAB000000, 32'h0,        2'b00, 1, 32'h000000AB, 1, 0);
        vecs[12] = mk(2'b01, 1, 0,  32'h0000,     32'h0000007F, 32'h0,        2'b00, 0, 32'h0000007F, 0, 0);
        vecs[13] = mk(2'b01, 1, 12, 32'h0000,     32'h0000F00F, 32'h0,        2'b01, 1, 32'h0000F00F, 1, 0);

        // Reset with junk on the inputs: reset must override accept.
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        drive(2'b00, 1, 5, 32'hFFFF_FFFF, 32'h0, 32'h0, 2'b00, 0);
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_wb_data", bus.wb_data, 0);
        check("rst_wb_reg_write", 32'(bus.wb_reg_write), 0);
        check("rst_wb_dest", 32'(bus.wb_dest), 0);
        check("rst_misalign", 32'(bus.misalign_err), 0);
        check("rst_count", 32'(bus.retired_count), 0);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_count", 32'(bus.retired_count), 0);

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].sel, vecs[i].rw, vecs[i].dest, vecs[i].alu, vecs[i].rd,
                  vecs[i].link, vecs[i].size, vecs[i].uns);
            @(negedge clk);
            bus.in_valid = 1'b0;
            check($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 1);
            if (!vecs[i].exp_mis) check($sformatf("vec%0d_wb_data", i), bus.wb_data, vecs[i].exp_data);
            check($sformatf("vec%0d_wb_dest", i), 32'(bus.wb_dest), 32'(vecs[i].dest));
            check($sformatf("vec%0d_wb_reg_write", i), 32'(bus.wb_reg_write), 32'(vecs[i].exp_write));
            check($sformatf("vec%0d_misalign", i), 32'(bus.misalign_err), 32'(vecs[i].exp_mis));
            @(negedge clk);
            exp_cnt++;
            check($sformatf("vec%0d_drained", i), 32'(bus.out_valid), 0);
            check($sformatf("vec%0d_count", i), 32'(bus.retired_count), exp_cnt % 16);
        end

        // Back-pressure: A held for two cycles while B waits, then B and C stream.
        bus.out_ready = 1'b0;
        drive(2'b00, 1, 5, 32'hA, 32'h0, 32'h0, 2'b00, 0);
        @(negedge clk);
        drive(2'b00, 1, 5, 32'hB, 32'h0, 32'h0, 2'b00, 0);
        #1;
        check("bp_hold1_data", bus.wb_data, 32'hA);
        check("bp_hold1_in_ready", 32'(bus.in_ready), 0);
        @(negedge clk);
        #1;
        check("bp_hold2_data", bus.wb_data, 32'hA);
        check("bp_hold2_in_ready", 32'(bus.in_ready), 0);
        check("bp_hold2_write", 32'(bus.wb_reg_write), 1);
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(bus.in_ready), 1);
        @(negedge clk);
        check("bp_b_data", bus.wb_data, 32'hB);
        drive(2'b00, 1, 5, 32'hC, 32'h0, 32'h0, 2'b00, 0);
        @(negedge clk);
        check("bp_c_data", bus.wb_data, 32'hC);
        bus.in_valid = 1'b0;
        @(negedge clk);
        exp_cnt += 3;
        check("bp_drained", 32'(bus.out_valid), 0);
        check("bp_count", 32'(bus.retired_count), exp_cnt % 16);

        // Flush while holding, with a new instruction offered: both are lost.
        bus.out_ready = 1'b0;
        drive(2'b00, 1, 9, 32'h111, 32'h0, 32'h0, 2'b00, 0);
        @(negedge clk);
        drive(2'b00, 1, 10, 32'h222, 32'h0, 32'h0, 2'b00, 0);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        check("flush_hold_valid", 32'(bus.out_valid), 0);
        check("flush_hold_write", 32'(bus.wb_reg_write), 0);
        repeat (2) @(negedge clk);
        check("flush_hold_stays_empty", 32'(bus.out_valid), 0);
        check("flush_hold_count", 32'(bus.retired_count), exp_cnt % 16);

        // Flush in the same cycle the held instruction completes: it still counts.
        bus.out_ready = 1'b0;
        drive(2'b00, 1, 9, 32'h333, 32'h0, 32'h0, 2'b00, 0);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        exp_cnt++;
        check("flush_comp_valid", 32'(bus.out_valid), 0);
        check("flush_comp_count", 32'(bus.retired_count), exp_cnt % 16);

        // Mid-hold reset drops the instruction without counting it.
        bus.out_ready = 1'b0;
        drive(2'b00, 1, 4, 32'h444, 32'h0, 32'h0, 2'b00, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        exp_cnt = 0;
        check("midhold_rst_valid", 32'(bus.out_valid), 0);
        check("midhold_rst_count", 32'(bus.retired_count), 0);

        // Sixteen back-to-back completions wrap the 4-bit counter to zero.
        for (int k = 0; k < 16; k++) begin
            drive(2'b00, 1, 1, 32'(k), 32'h0, 32'h0, 2'b00, 0);
            @(negedge clk);
            if (k > 0) check($sformatf("stream%0d_data", k), bus.wb_data, 32'(k));
        end
        bus.in_valid = 1'b0;
        check("wrap_count15", 32'(bus.retired_count), 15);
        @(negedge clk);
        check("wrap_count0", 32'(bus.retired_count), 0);

        // Randomized traffic against the cycle-level model.
        m_valid = 0; m_data = '0; m_dest = '0; m_write = 0; m_mis = 0; m_cnt = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            check("rnd_out_valid", 32'(bus.out_valid), 32'(m_valid));
            check("rnd_wb_reg_write", 32'(bus.wb_reg_write), 32'(m_valid && m_write));
            check("rnd_count", 32'(bus.retired_count), m_cnt);
            if (m_valid) begin
                check("rnd_wb_dest", 32'(bus.wb_dest), 32'(m_dest));
                check("rnd_misalign", 32'(bus.misalign_err), 32'(m_mis));
                if (!m_mis) check("rnd_wb_data", bus.wb_data, m_data);
            end
            drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            bus.flush     = ($urandom_range(0, 11) == 0);
            #1;
            check("rnd_in_ready", 32'(bus.in_ready), 32'(!m_valid || bus.out_ready));

            acc  = bus.in_valid && (!m_valid || bus.out_ready) && !bus.flush;
            comp = m_valid && bus.out_ready;
            if (comp && m_write) exp_q.push_back(m_data);
            if (bus.out_valid && bus.out_ready && bus.wb_reg_write) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_write", 32'(bus.wb_dest), 32'hFFFF_FFFF);
                end else begin
                    got = exp_q.pop_front();
                    check("sb_wb_data", bus.wb_data, got);
                end
            end

            r = ref_model(bus.in_wb_sel, bus.in_reg_write, bus.in_dest, bus.in_alu_result,
                          bus.in_read_data, bus.in_link_addr, bus.in_load_size,
                          bus.in_load_unsigned);
            if (comp) m_cnt = (m_cnt + 1) % 16;
            if (acc) begin
                m_valid = 1; m_data = r.data; m_dest = bus.in_dest;
                m_write = r.write; m_mis = r.mis;
            end else if (comp || bus.flush) begin
                m_valid = 0; m_write = 0;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        check("sb_missing_writes", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_stage_pipe.md
# wb_stage_pipe

Parametrised, clocked writeback stage for the MIPS pipeline, sitting between the MEM/WB boundary and the register file write port. It registers one instruction per accepted transfer and selects the writeback value from ALU result, load data or link address. It sign/zero-extends sub-word loads, suppresses writes to register 0 and to misaligned loads, and exposes the registered result as a forwarding source. It also applies valid/ready back-pressure and flush, and counts retired instructions.

## Interface
Parameters:
- DATA_W, 32, datapath width; multiple of 32 (32 or 64).
- REG_ADDR_W, 5, register index width.
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard held instruction and any input this cycle.
- in_valid  in  1  input instruction present.
- in_ready  out  1  stage can accept; = !out_valid || out_ready.
- in_wb_sel  in  2  00 ALU, 01 memory, 10 link, 11 treated as ALU.
- in_reg_write  in  1  instruction writes a register.
- in_dest  in  REG_ADDR_W  destination register.
- in_alu_result  in  DATA_W  ALU result; low bits are the load byte address.
- in_read_data  in  DATA_W  raw memory word, little-endian lanes.
- in_link_addr  in  DATA_W  return address for link instructions.
- in_load_size  in  2  00 byte, 01 half, 10 word (32b), 11 full DATA_W.
- in_load_unsigned  in  1  zero-extend when set, else sign-extend.
- out_valid  out  1  held instruction valid.
- out_ready  in  1  register file port accepts this cycle.
- wb_data  out  DATA_W  writeback value.
- wb_reg_write  out  1  register file write strobe; = out_valid && gated reg_write.
- wb_dest  out  REG_ADDR_W  writeback destination.
- misalign_err  out  1  held instruction is a misaligned load.
- retired_count  out  CNT_W  count of completed transfers.

## Operation
- Accept: in_valid && in_ready && !flush. The held register loads the selected, extended data, dest, gated reg_write and misalign flag, and out_valid is set.
- Complete: out_valid && out_ready. If no accept occurs the same cycle, out_valid clears. Accept and complete in the same cycle give back-to-back throughput of 1/cycle.
- Hold: out_valid && !out_ready keeps all outputs stable and drives in_ready low.
- Memory select: lane offset = in_alu_result[log2(DATA_W/8)-1:0].
  - Byte: extract byte at the offset.
  - Half: extract the 16 bits at the offset.
  - Word: extract the 32 bits at the offset.
  - Full: whole word.
  - Extension: to DATA_W per in_load_unsigned.
- Alignment: half needs offset[0]=0. Word needs offset[1:0]=0. Full needs offset=0.
  - A misaligned load sets misalign_err and forces reg_write to 0.
  - Alignment and misalign_err apply only when in_wb_sel=01.
- Gating: in_dest=0 forces reg_write to 0. wb_data is still the computed value.
- ALU and link selects pass through unchanged. In_load_size is ignored for them.
- Forwarding: downstream hazard logic uses wb_dest/wb_data/wb_reg_write directly. All are registered outputs with no combinational path from inputs.
- retired_count increments by 1 on every complete, including non-writing and misaligned instructions. It wraps from 2^CNT_W-1 to 0. It is not affected by flush.

## Timing
- Latency: 1 cycle from accept to out_valid/wb_* visible.
- Reset (rst=1 at a clock edge): all of the following clear to 0: out_valid, wb_data, wb_reg_write, wb_dest, misalign_err, retired_count. Reset overrides flush, accept and complete. Mid-hold reset drops the held instruction with no count.
- Flush: at the next edge out_valid=0 and wb_reg_write=0. Input that cycle is dropped. A held instruction completing in the same cycle (out_ready=1) still counts.
- Flush while holding: the instruction is discarded and never written.
- in_ready is combinational from out_valid and out_ready only.

## Test plan
- Reset then idle: assert rst 2 cycles -> all outputs 0, in_ready=1. Release -> retired_count stays 0.
- Signed byte load: sel=01, size=00, unsigned=0, alu_result=0x1002, read_data=0x11_80_33_44, dest=8 -> next cycle wb_data=0xFFFFFF80, wb_dest=8, wb_reg_write=1. Repeat with unsigned=1 -> wb_data=0x00000080.
- Misaligned half: sel=01, size=01, alu_result=0x3 -> misalign_err=1, wb_reg_write=0. retired_count +1 on complete.
- Back-pressure: three back-to-back instructions (ALU, dest=5, data 0xA/0xB/0xC), out_ready=0 for 2 cycles after the first -> wb_data holds 0xA, in_ready=0. All three complete in order. retired_count=3.
- Register 0 and link: sel=10, link=0x00400008, dest=31 -> wb_data=0x00400008, write=1. Same with dest=0 -> write=0.
- Flush and wrap: CNT_W=4, 16 completes -> retired_count=0. Flush while holding with in_valid=1 -> out_valid=0 next cycle and neither instruction is written.
